// File: rtl/cu_data_write_command_buffer.sv
// Write command buffer: FIFO of {command, data_0, data_1} entries issued
// downstream when the AFU write command buffer is not almost full.
package cu_data_write_pkg;

   localparam int ARRAY_SIZE_BITS = 32;
   localparam int DATA_W          = 256;

   typedef struct packed {
      logic        valid;
      logic [12:0] command;
      logic [7:0]  tag;
      logic [11:0] size;
      logic [63:0] address;
   } CommandBufferLine;

   typedef struct packed {
      logic              valid;
      logic [7:0]        tag;
      logic [DATA_W-1:0] data;
   } ReadWriteDataLine;

   typedef struct packed {
      logic       valid;
      logic [7:0] tag;
      logic [7:0] response;
   } ResponseBufferLine;

   typedef struct packed {
      logic valid;
      logic empty;
      logic alfull;
      logic full;
   } BufferStatus;

   typedef struct packed {
      CommandBufferLine cmd;
      ReadWriteDataLine data_0;
      ReadWriteDataLine data_1;
   } WriteCmdEntry;

endpackage

module cu_data_write_command_buffer
   import cu_data_write_pkg::*;
#(
   parameter int WRITE_CMD_BUF_DEPTH  = 16,
   parameter int WRITE_CMD_BUF_ALFULL = 12
) (
   input  logic                       clock,
   input  logic                       rstn,
   input  logic                       enabled_in,
   input  CommandBufferLine           write_command_in,
   input  ReadWriteDataLine           write_data_0_in,
   input  ReadWriteDataLine           write_data_1_in,
   input  ResponseBufferLine          write_response_in,
   input  BufferStatus                write_command_buffer_status,
   output CommandBufferLine           write_command_out,
   output ReadWriteDataLine           write_data_0_out,
   output ReadWriteDataLine           write_data_1_out,
   output BufferStatus                write_buffer_status_out,
   output logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done,
   output logic [ARRAY_SIZE_BITS-1:0] write_outstanding_out,
   output logic                       write_overflow_error
);

   localparam int AW = $clog2(WRITE_CMD_BUF_DEPTH);
   localparam logic [AW:0] FULL_V = (AW+1)'(WRITE_CMD_BUF_DEPTH);
   localparam logic [AW:0] ALF_V  = (AW+1)'(WRITE_CMD_BUF_ALFULL);

   WriteCmdEntry mem_q [WRITE_CMD_BUF_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   WriteCmdEntry  out_q, out_d;
   logic [ARRAY_SIZE_BITS-1:0] done_q, done_d;
   logic [ARRAY_SIZE_BITS-1:0] outst_q, outst_d;
   logic          ovf_q, ovf_d;

   logic empty, full, alfull, push, pop, resp;
   logic unused_in;

   assign unused_in = ^{write_response_in.tag,
                        write_response_in.response,
                        write_command_buffer_status.valid,
                        write_command_buffer_status.empty,
                        write_command_buffer_status.full};

   always_comb begin
      empty = (occ_q == '0);
      full  = (occ_q == FULL_V);
      alfull = (occ_q >= ALF_V);
      resp  = write_response_in.valid;
      pop   = enabled_in & ~empty & ~write_command_buffer_status.alfull;
      // a pop in the same cycle frees the slot a push at full needs
      push  = enabled_in & write_command_in.valid & (~full | pop);

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);

      out_d = '0;
      if (pop) begin
         out_d           = mem_q[rd_ptr_q];
         out_d.cmd.valid = 1'b1;
      end

      ovf_d  = ovf_q | (enabled_in & write_command_in.valid & full & ~pop);
      done_d = done_q + ARRAY_SIZE_BITS'(resp);

      outst_d = outst_q;
      if (pop && !resp) begin
         outst_d = outst_q + 1'b1;
      end else if (!pop && resp && outst_q != '0) begin
         outst_d = outst_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         out_q    <= '0;
         done_q   <= '0;
         outst_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         out_q    <= out_d;
         done_q   <= done_d;
         outst_q  <= outst_d;
         ovf_q    <= ovf_d;
      end
   end

   // storage needs no reset: pointers and occupancy define what is live
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{cmd:    write_command_in,
                              data_0: write_data_0_in,
                              data_1: write_data_1_in};
      end
   end

   always_comb begin
      write_buffer_status_out        = '0;
      write_buffer_status_out.valid  = ~empty;
      write_buffer_status_out.empty  = empty;
      write_buffer_status_out.alfull = alfull;
      write_buffer_status_out.full   = full;
   end

   assign write_command_out      = out_q.cmd;
   assign write_data_0_out       = out_q.data_0;
   assign write_data_1_out       = out_q.data_1;
   assign write_job_counter_done = done_q;
   assign write_outstanding_out  = outst_q;
   assign write_overflow_error   = ovf_q;

endmodule
